bram_seq_ctrl: RTL

- Sequences a single-port block RAM test datapath under AXI-Lite register control: a fill pass, then a timed read-back pass.
- Sits between the AXI-Lite slave register file and the BRAM. slv_reg0 drives i_mode, slv_reg1 drives i_count_max, slv_reg2 reads o_set_count, slv_reg3 reads o_clk_counter.
- Owns all BRAM enable, write and address sequencing, and the cycle counting for the read pass.

---
 rtl/bram_seq_ctrl.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/bram_seq_ctrl.sv
// bram_seq_ctrl: fill / timed read-back sequencer for a single-port BRAM.
//
// The optional read-back compare is built only when the macro
// BRAM_SEQ_CTRL_ERR_CHECK_EN is defined. Otherwise o_err_count is tied to 0.
//
// state | meaning
// IDLE  | BRAM disabled, waiting for a fresh write or read command
// WR    | one write per cycle, address 0..N-1, data = address + SEED
// RD    | one read per cycle, address 0..N-1, cycle counter running
// DRAIN | no new reads; wait RD_LAT cycles for the last data, counter running
// DONE  | pass finished, counters held, wait for mode 0 or 3
module bram_seq_ctrl #(
    parameter int            DW     = 32,
    parameter int            AW     = 10,
    parameter int            RD_LAT = 1,
    parameter logic [DW-1:0] SEED   = '0
) (
    input  logic          iclk,
    input  logic          irstn,
    input  logic [1:0]    i_mode,
    input  logic [DW-1:0] i_count_max,
    output logic [DW-1:0] o_set_count,
    output logic [DW-1:0] o_clk_counter,
    output logic [DW-1:0] o_err_count,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_mem_en,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_wdata,
    input  logic [DW-1:0] i_mem_rdata
);

    localparam int DEPTH = 2 ** AW;
    localparam int CW    = AW + 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR    = 3'd1,
        RD    = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t        state_q;
    logic [1:0]    mode_q;
    logic [CW-1:0] n_q;
    logic [CW-1:0] n_d;
    logic [CW-1:0] cnt_q;
    logic [1:0]    drain_q;
    logic          en_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] set_q;
    logic [DW-1:0] clk_cnt_q;
    logic          busy_q;
    logic          done_q;
    logic          start_wr;
    logic          start_rd;
    logic          abort;

    assign start_wr = (i_mode == 2'd1) && (mode_q != 2'd1) && (state_q == IDLE);
    assign start_rd = (i_mode == 2'd2) && (mode_q != 2'd2) && (state_q == IDLE);
    assign abort    = (i_mode == 2'd0) || (i_mode == 2'd3);

    // Word count for a new pass: 0 and anything beyond DEPTH mean a full pass.
    always_comb begin
        n_d = CW'(DEPTH);
        if ((i_count_max != '0) && (i_count_max <= DW'(DEPTH))) begin
            n_d = i_count_max[CW-1:0];
        end
    end

    // Main sequencer. BRAM command and counters are registered together, so the
    // command for word a and the counter step for word a appear on the same edge.
    // cnt_q counts words issued so far and doubles as the next address.
    always_ff @(posedge iclk or negedge irstn) begin
        if (!irstn) begin
            state_q   <= IDLE;
            mode_q    <= 2'd0;
            n_q       <= '0;
            cnt_q     <= '0;
            drain_q   <= '0;
            en_q      <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            set_q     <= '0;
            clk_cnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            mode_q <= i_mode;
            case (state_q)
                IDLE: begin
                    en_q   <= 1'b0;
                    we_q   <= 1'b0;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    if (start_wr) begin
                        state_q <= WR;
                        n_q     <= n_d;
                        en_q    <= 1'b1;
                        we_q    <= 1'b1;
                        addr_q  <= '0;
                        wdata_q <= SEED;
                        set_q   <= DW'(1);
                        cnt_q   <= CW'(1);
                        busy_q  <= 1'b1;
                    end else if (start_rd) begin
                        state_q   <= RD;
                        n_q       <= n_d;
                        en_q      <= 1'b1;
                        we_q      <= 1'b0;
                        addr_q    <= '0;
                        clk_cnt_q <= DW'(1);
                        cnt_q     <= CW'(1);
                        busy_q    <= 1'b1;
                    end
                end
                WR: begin
                    if (abort) begin
                        state_q <= IDLE;
                        en_q    <= 1'b0;
                        we_q    <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == n_q) begin
                        state_q <= DONE;
                        en_q    <= 1'b0;
                        we_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        en_q    <= 1'b1;
                        we_q    <= 1'b1;
                        addr_q  <= cnt_q[AW-1:0];
                        wdata_q <= DW'(cnt_q[AW-1:0]) + SEED;
                        set_q   <= set_q + DW'(1);
                        cnt_q   <= cnt_q + CW'(1);
                    end
                end
                RD: begin
                    if (abort) begin
                        state_q <= IDLE;
                        en_q    <= 1'b0;
                        we_q    <= 1'b0;
                        busy_q  <= 1'b0;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + DW'(1);
                        if (cnt_q == n_q) begin
                            state_q <= DRAIN;
                            en_q    <= 1'b0;
                            drain_q <= '0;
                        end else begin
                            en_q   <= 1'b1;
                            addr_q <= cnt_q[AW-1:0];
                            cnt_q  <= cnt_q + CW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (abort) begin
                        state_q <= IDLE;
                        en_q    <= 1'b0;
                        we_q    <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (drain_q == 2'(RD_LAT - 1)) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        drain_q   <= drain_q + 2'd1;
                        clk_cnt_q <= clk_cnt_q + DW'(1);
                    end
                end
                DONE: begin
                    en_q <= 1'b0;
                    we_q <= 1'b0;
                    if (abort) begin
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    en_q    <= 1'b0;
                    we_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_set_count   = set_q;
    assign o_clk_counter = clk_cnt_q;
    assign o_busy        = busy_q;
    assign o_done        = done_q;
    assign o_mem_en      = en_q;
    assign o_mem_we      = we_q;
    assign o_mem_addr    = addr_q;
    assign o_mem_wdata   = wdata_q;

`ifdef BRAM_SEQ_CTRL_ERR_CHECK_EN
    logic [RD_LAT-1:0] pv_q;
    logic [DW-1:0]     pe_q [RD_LAT];
    logic [DW-1:0]     err_q;
    logic              cmp_window;

    assign cmp_window = (state_q == RD) || (state_q == DRAIN);

    // Expected-data pipe aligned with BRAM latency; flushed on a new read so
    // leftovers from an aborted pass never reach the compare.
    always_ff @(posedge iclk or negedge irstn) begin
        if (!irstn) begin
            pv_q <= '0;
            for (int i = 0; i < RD_LAT; i++) pe_q[i] <= '0;
        end else begin
            if (start_rd) begin
                pv_q <= '0;
            end else begin
                pv_q[0] <= en_q & ~we_q;
                for (int i = 1; i < RD_LAT; i++) pv_q[i] <= pv_q[i-1];
            end
            pe_q[0] <= DW'(addr_q) + SEED;
            for (int i = 1; i < RD_LAT; i++) pe_q[i] <= pe_q[i-1];
        end
    end

    // Saturating mismatch counter, cleared when a read pass starts.
    always_ff @(posedge iclk or negedge irstn) begin
        if (!irstn) begin
            err_q <= '0;
        end else if (start_rd) begin
            err_q <= '0;
        end else if (cmp_window && pv_q[RD_LAT-1] &&
                     (i_mem_rdata != pe_q[RD_LAT-1]) && (err_q != '1)) begin
            err_q <= err_q + DW'(1);
        end
    end

    assign o_err_count = err_q;
`else
    logic unused_rdata;
    assign unused_rdata = ^i_mem_rdata;
    assign o_err_count  = '0;
`endif

endmodule
